// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the serial program loader.
package prog_loader_pkg;

  localparam int unsigned DEF_LINE_WIDTH    = 32;
  localparam int unsigned DEF_IP_WIDTH      = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    L_IDLE  = 3'd0,
    L_DATA  = 3'd1,
    L_WRITE = 3'd2,
    L_DONE  = 3'd3,
    L_ERR   = 3'd4
  } LoaderState;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // A line count is legal when it is non-zero and fits the line memory.
  // Once the memory holds 256 or more lines every 8-bit count fits.
  function automatic logic count_ok(input logic [7:0] n, input int unsigned ip_width);
    int unsigned max_lines;
    max_lines = (ip_width >= 8) ? 32'd256 : (32'd1 << ip_width);
    return (n != 8'd0) && (32'(n) <= max_lines);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Line-memory write port plus CPU control/status bundle.
interface prog_loader_if #(
  parameter int unsigned LINE_WIDTH = prog_loader_pkg::DEF_LINE_WIDTH,
  parameter int unsigned IP_WIDTH   = prog_loader_pkg::DEF_IP_WIDTH
);
  logic                  wr_en;
  logic [IP_WIDTH-1:0]   wr_addr;
  logic [LINE_WIDTH-1:0] wr_data;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (output wr_en, wr_addr, wr_data, start, busy, done, err);
  modport slave  (input  wr_en, wr_addr, wr_data, start, busy, done, err);
endinterface

// File: rtl/prog_loader_uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting start.
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_e   state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic        prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        rx_s;

  assign rx_s = sync_q[1];

  // Next-state: frame detection, bit timing and stop-bit check.
  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], rx};
    prev_d  = rx_s;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          cnt_d   = '0;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s) begin
            valid_d = 1'b1;
            byte_d  = shreg_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // State register; synchronizer resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= RX_IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: packs received bytes into lines, writes them, starts the CPU.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned LINE_WIDTH   = DEF_LINE_WIDTH,
  parameter int unsigned IP_WIDTH     = DEF_IP_WIDTH,
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx,
  prog_loader_if.master bus
);

  localparam int unsigned BYTES = LINE_WIDTH / 8;
  localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (rx),
    .byte_out   (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_ferr)
  );

  LoaderState            state_q, state_d;
  logic [7:0]            n_q, n_d;
  logic [IP_WIDTH-1:0]   addr_q, addr_d;
  logic [BCW-1:0]        bcnt_q, bcnt_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic                  wr_en_q, wr_en_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  last_line;

  assign last_line = (32'(addr_q) == (32'(n_q) - 32'd1));

  // Loader next-state: count byte, line packing, write, completion, error trap.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    bcnt_d  = bcnt_q;
    line_d  = line_q;
    wr_en_d = 1'b0;
    start_d = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      L_IDLE: begin
        if (rx_valid) begin
          if (count_ok(rx_byte, IP_WIDTH)) begin
            n_d     = rx_byte;
            addr_d  = '0;
            bcnt_d  = '0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = L_DATA;
          end else begin
            state_d = L_ERR;
          end
        end
      end
      L_DATA: begin
        if (rx_valid) begin
          line_d = (line_q << 8) | LINE_WIDTH'(rx_byte);
          if (bcnt_q == LAST_BYTE) begin
            wr_en_d = 1'b1;
            state_d = L_WRITE;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end
      end
      L_WRITE: begin
        if (last_line) begin
          start_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = L_DONE;
        end else begin
          addr_d  = addr_q + IP_WIDTH'(1);
          bcnt_d  = '0;
          state_d = L_DATA;
        end
      end
      L_DONE:  state_d = L_IDLE;
      L_ERR:   state_d = L_ERR;
      default: state_d = L_ERR;
    endcase
    // A bad count or a framing error traps the loader until reset.
    if ((state_d == L_ERR) || (rx_ferr && state_q != L_ERR)) begin
      state_d = L_ERR;
      wr_en_d = 1'b0;
      start_d = 1'b0;
      busy_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  // Loader registers; reset discards any partial line.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= L_IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      bcnt_q  <= '0;
      line_q  <= '0;
      wr_en_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      bcnt_q  <= bcnt_d;
      line_q  <= line_d;
      wr_en_q <= wr_en_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = line_q;
  assign bus.start   = start_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with CLKS_PER_BIT=16, LINE_WIDTH=16, IP_WIDTH=4.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int unsigned CPB = 16;
  localparam int unsigned LW  = 16;
  localparam int unsigned IPW = 4;
  localparam int unsigned GAP = 24;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [IPW-1:0] wa_q[$];
  logic [LW-1:0]  wd_q[$];
  int start_cnt = 0;
  int start_cyc = -1;
  int last_wr_cyc = -1;
  int bv_cnt = 0;

  prog_loader_if #(.LINE_WIDTH(LW), .IP_WIDTH(IPW)) bus ();

  prog_loader #(.LINE_WIDTH(LW), .IP_WIDTH(IPW), .CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      last_wr_cyc = cyc;
    end
    if (bus.start) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
    end
    if (dut.rx_valid) bv_cnt = bv_cnt + 1;
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    start_cnt = 0;
    start_cyc = -1;
    last_wr_cyc = -1;
    bv_cnt = 0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rstn = 1'b0;
    repeat (cycles) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
    total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", bus.start); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    total++; if (bus.wr_addr !== 4'h0) begin bad++; $display("FAIL reset_wr_addr got=%h exp=0", bus.wr_addr); end
    total++; if (bus.wr_data !== 16'h0000) begin bad++; $display("FAIL reset_wr_data got=%h exp=0", bus.wr_data); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    clear_log();
  endtask

  task automatic test_two_lines();
    send_byte(8'h02, 1'b1);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL two_busy_after_count got=%b exp=1", bus.busy); end
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    total++; if (wa_q.size() !== 2) begin bad++; $display("FAIL two_write_count got=%0d exp=2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      total++; if (wa_q[0] !== 4'd0) begin bad++; $display("FAIL two_addr0 got=%h exp=0", wa_q[0]); end
      total++; if (wd_q[0] !== 16'hABCD) begin bad++; $display("FAIL two_data0 got=%h exp=abcd", wd_q[0]); end
      total++; if (wa_q[1] !== 4'd1) begin bad++; $display("FAIL two_addr1 got=%h exp=1", wa_q[1]); end
      total++; if (wd_q[1] !== 16'h1234) begin bad++; $display("FAIL two_data1 got=%h exp=1234", wd_q[1]); end
    end
    total++; if (start_cnt !== 1) begin bad++; $display("FAIL two_start_count got=%0d exp=1", start_cnt); end
    total++; if (start_cyc !== last_wr_cyc + 1) begin bad++; $display("FAIL two_start_cycle got=%0d exp=%0d", start_cyc, last_wr_cyc + 1); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL two_done got=%b exp=1", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL two_busy_end got=%b exp=0", bus.busy); end
  endtask

  task automatic test_frame_err();
    do_reset(2);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b0);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL ferr_err got=%b exp=1", bus.err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ferr_busy got=%b exp=0", bus.busy); end
    total++; if (wa_q.size() !== 0) begin bad++; $display("FAIL ferr_writes got=%0d exp=0", wa_q.size()); end
    total++; if (start_cnt !== 0) begin bad++; $display("FAIL ferr_start got=%0d exp=0", start_cnt); end
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    total++; if (wa_q.size() !== 0) begin bad++; $display("FAIL ferr_sticky_writes got=%0d exp=0", wa_q.size()); end
    total++; if (start_cnt !== 0) begin bad++; $display("FAIL ferr_sticky_start got=%0d exp=0", start_cnt); end
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL ferr_sticky_err got=%b exp=1", bus.err); end
  endtask

  task automatic test_bad_count();
    do_reset(2);
    send_byte(8'h00, 1'b1);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL cnt0_err got=%b exp=1", bus.err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL cnt0_busy got=%b exp=0", bus.busy); end
    do_reset(2);
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL cnt_reset_clears_err got=%b exp=0", bus.err); end
    send_byte(8'h11, 1'b1);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL cnt17_err got=%b exp=1", bus.err); end
    do_reset(2);
    send_byte(8'h10, 1'b1);
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL cnt16_err got=%b exp=0", bus.err); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL cnt16_busy got=%b exp=1", bus.busy); end
  endtask

  task automatic test_glitch();
    do_reset(2);
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    total++; if (bv_cnt !== 0) begin bad++; $display("FAIL glitch_byte_valid got=%0d exp=0", bv_cnt); end
    total++; if (dut.state_q !== L_IDLE) begin bad++; $display("FAIL glitch_state got=%0d exp=%0d", dut.state_q, L_IDLE); end
    total++; if ({bus.wr_en, bus.start, bus.busy, bus.done, bus.err} !== 5'b0) begin
      bad++; $display("FAIL glitch_outputs got=%b exp=00000", {bus.wr_en, bus.start, bus.busy, bus.done, bus.err});
    end
  endtask

  task automatic test_reset_midload();
    do_reset(2);
    send_byte(8'h01, 1'b1);
    send_byte(8'hDE, 1'b1);
    total++; if (wa_q.size() !== 0) begin bad++; $display("FAIL mid_no_write got=%0d exp=0", wa_q.size()); end
    do_reset(1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    total++; if (wa_q.size() !== 1) begin bad++; $display("FAIL mid_write_count got=%0d exp=1", wa_q.size()); end
    if (wa_q.size() == 1) begin
      total++; if (wa_q[0] !== 4'd0) begin bad++; $display("FAIL mid_addr got=%h exp=0", wa_q[0]); end
      total++; if (wd_q[0] !== 16'h55AA) begin bad++; $display("FAIL mid_data got=%h exp=55aa", wd_q[0]); end
    end
    total++; if (start_cnt !== 1) begin bad++; $display("FAIL mid_start got=%0d exp=1", start_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%b exp=1", bus.done); end
    clear_log();
    send_byte(8'h01, 1'b1);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_done_drop got=%b exp=0", bus.done); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", bus.busy); end
    send_byte(8'h00, 1'b1);
    send_byte(8'h07, 1'b1);
    total++; if (wa_q.size() !== 1) begin bad++; $display("FAIL b2b_write_count got=%0d exp=1", wa_q.size()); end
    if (wa_q.size() == 1) begin
      total++; if (wa_q[0] !== 4'd0) begin bad++; $display("FAIL b2b_addr got=%h exp=0", wa_q[0]); end
      total++; if (wd_q[0] !== 16'h0007) begin bad++; $display("FAIL b2b_data got=%h exp=0007", wd_q[0]); end
    end
    total++; if (start_cnt !== 1) begin bad++; $display("FAIL b2b_start got=%0d exp=1", start_cnt); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", bus.done); end
  endtask

  initial begin
    test_reset();
    test_two_lines();
    test_frame_err();
    test_bad_count();
    test_glitch();
    test_reset_midload();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader that sits directly upstream of the CPU. It receives a program over a UART-style 8N1 line and packs the bytes into `LINE_WIDTH`-bit instruction lines. It writes those lines into the line memory through a write port, then pulses the CPU `start` input once the whole program is loaded. While a load is in progress it holds the CPU idle through `busy`.

## Interface
Parameters:
- `LINE_WIDTH`, default from `params.svh`: instruction line width; must be a multiple of 8.
- `IP_WIDTH`, default from `params.svh`: line-memory address width.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be even and ≥ 4.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `rx`  in  1  serial input; idles high; asynchronous to `clk`.
- `wr_en`  out  1  line-memory write strobe, one cycle per line.
- `wr_addr`  out  `IP_WIDTH`  line address being written.
- `wr_data`  out  `LINE_WIDTH`  packed line.
- `start`  out  1  one-cycle pulse to the CPU `start` input.
- `busy`  out  1  high from a valid count byte until the final write.
- `done`  out  1  high after a successful load; cleared by the next count byte.
- `err`  out  1  sticky protocol or framing error; cleared only by `rstn`.

## Operation
Protocol:
- Byte 0 is N, the number of lines.
- N × B data bytes follow, where B = `LINE_WIDTH`/8.
- Bytes within a line arrive MSB first: the first byte lands in `wr_data[LINE_WIDTH-1 -: 8]`.

Receiver (uart_rx):
- `rx` passes through a 2-flop synchronizer.
- A falling edge in RX_IDLE starts a frame. The start bit is resampled at `CLKS_PER_BIT`/2; if it reads high, this is a glitch and the receiver returns to RX_IDLE.
- Eight data bits follow, sampled every `CLKS_PER_BIT`, LSB first. The stop bit is sampled one period later.
- Stop bit = 1: `byte_valid` pulses for one cycle. Stop bit = 0: `frame_err` pulses for one cycle.
- After the stop-bit sample the receiver returns to RX_IDLE immediately.

Loader FSM (`LoaderState`):
- L_IDLE: waits for a byte.
  - N = 0, or N > 2^`IP_WIDTH`: go to L_ERR.
  - Otherwise: latch N, clear `wr_addr` and the byte counter, clear `done`, set `busy`, go to L_DATA.
- L_DATA: each `byte_valid` shifts the byte into the line buffer. On the B-th byte go to L_WRITE.
- L_WRITE: assert `wr_en` for one cycle.
  - If `wr_addr` = N−1: go to L_DONE.
  - Otherwise: increment `wr_addr`, clear the byte counter, return to L_DATA.
- L_DONE: pulse `start` for one cycle, clear `busy`, set `done`, go to L_IDLE.
- L_ERR: `err` = 1 and `busy` = 0. No further writes or `start`. Incoming bytes are ignored. Exit only by reset.
- `frame_err` in any state other than L_ERR sends the FSM to L_ERR.
- A new count byte after a completed load starts a fresh load from address 0. Memory contents beyond the new N are left untouched.

Width rules:
- N is 8 bits.
- The comparison against 2^`IP_WIDTH` is done at `IP_WIDTH`+1 bits. When `IP_WIDTH` ≥ 8, every N from 1 to 255 is legal.

## Timing
- Reset (at a `rstn`-low edge): both FSMs go to idle. `wr_en`, `start`, `busy`, `done`, `err` = 0. `wr_addr` = 0. `wr_data` = 0. Synchronizer flops are set to 1.
- Reset mid-load discards the partial line. No write is issued.
- Latency from `rx` to `byte_valid`: 2 synchronizer cycles + 9.5 × `CLKS_PER_BIT`, ±1 cycle.
- `wr_en` is high exactly in the cycle after the `byte_valid` of the last byte of a line.
- `wr_addr` and `wr_data` are stable in that same cycle.
- `start` pulses in the cycle immediately after the final `wr_en`.
- `done` and `busy` = 0 update in the same cycle as `start`.
- A `byte_valid` can never coincide with L_WRITE or L_DONE, because byte spacing is ≥ 10 × `CLKS_PER_BIT`. No buffering is required.

## Structure
- Add to `params.svh`: a `LoaderState` enum (L_IDLE, L_DATA, L_WRITE, L_DONE, L_ERR) and a `UART_CLKS_PER_BIT` default constant.
- One sub-module, `uart_rx`:
  - Ports: `clk`, `rstn`, `rx`, `byte_out[7:0]`, `byte_valid`, `frame_err`.
  - Holds the synchronizer, the bit-timer counter and the bit counter.
- `prog_loader` holds the loader FSM, line shift buffer, byte counter, address counter and N register.

## Test plan
Bench settings: `CLKS_PER_BIT`=16, `LINE_WIDTH`=16, `IP_WIDTH`=4.
- Send 0x02, 0xAB, 0xCD, 0x12, 0x34 -> writes (0, 0xABCD) then (1, 0x1234). `start` pulses once, the cycle after the second write. Final state: `done`=1, `busy`=0.
- Send 0x01 and 0x55, then a frame 0x66 with stop bit 0 -> `err`=1. No `wr_en` and no `start`. A following valid stream produces no writes until `rstn` is pulsed.
- Send count 0x00 -> `err`=1. After reset, send count 0x11 (17 > 16) -> `err`=1.
- Drive `rx` low for 4 cycles, then high -> no `byte_valid`, FSM stays in L_IDLE, all outputs 0.
- Send 0x01 and 0xDE, hold `rstn` low for one cycle, then send 0x01, 0x55, 0xAA -> no write before the reset. Then exactly one write (0, 0x55AA) and one `start`.
- After a completed load of 0x02, send 0x01, 0x00, 0x07 -> `done` drops at the count byte and `busy`=1. One write (0, 0x0007), then `start` and `done`=1.
